// File: rtl/programmable_sequence_detector.sv
// Serial pattern detector with a runtime-loadable pattern (1..MAX_LEN bits) and
// overlapping/non-overlapping matching. Optional saturating counter: SEQDET_MATCH_COUNTER_EN.
module programmable_sequence_detector #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               seq,
  input  logic               valid,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(5);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(5'b10110);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   cfg_len_c;
  logic               accept;
  logic               match;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cfg_len_c = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    accept    = valid && !cfg_load;
    hist_n    = (hist << 1) | MAX_LEN'(seq);
    fill_n    = (fill == LEN_MAX) ? LEN_MAX : fill + LEN_W'(1);
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    match = accept && (len_q != '0) && (fill_n >= len_q) &&
            ((hist_n & mask) == (pat_q & mask));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q    <= PAT_RST;
      len_q    <= LEN_RST;
      ovl_q    <= 1'b1;
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else begin
      detected <= match;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len_c;
        ovl_q <= cfg_overlap;
        hist  <= '0;
        fill  <= '0;
      end else if (valid) begin
        hist <= hist_n;
        // Non-overlap restarts collection; stale history bits are masked out by fill.
        fill <= (match && !ovl_q) ? '0 : fill_n;
      end
    end
  end

`ifdef SEQDET_MATCH_COUNTER_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      count_q <= '0;
    end else if (match && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/programmable_sequence_detector.md
# programmable_sequence_detector

Serial bit-stream pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits and selectable overlapping or non-overlapping matching. An optional saturating match counter is included. It replaces the fixed-pattern `10110` detector in the datapath: one bit per accepted `valid` cycle goes in, and a registered one-cycle `detected` pulse comes out.

## Interface
- `MAX_LEN`, default 16: maximum pattern length in bits; legal range 5..32.
- `CNT_W`, default 16: width of `match_count`.
- `LEN_W`, derived `$clog2(MAX_LEN+1)`: width of `cfg_len`.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cfg_load` input 1: latch the `cfg_*` inputs and clear the match history.
- `cfg_pattern` input MAX_LEN: pattern, right-aligned; bit `[len-1]` is the oldest bit and bit `[0]` the newest.
- `cfg_len` input LEN_W: pattern length.
- `cfg_overlap` input 1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- `seq` input 1: serial data bit.
- `valid` input 1: `seq` is accepted on any rising edge where this is high.
- `detected` output 1: one-cycle pulse, high the cycle after the accepted bit that completes a match.
- `match_count` output CNT_W: number of matches; saturates at all-ones.

## Operation
- Active configuration registers: `pat_q`, `len_q`, `ovl_q`.
  - Reset values: `pat_q` = `10110` zero-extended, `len_q` = 5, `ovl_q` = 1.
- Effective length `len_e`:
  - If `cfg_len` > MAX_LEN, it is clamped to MAX_LEN at load.
  - `len_q` = 0 disables detection; `detected` stays 0.
- Internal state:
  - `hist`: MAX_LEN-bit shift register.
  - `fill`: count of valid bits collected since the last clear; saturates at MAX_LEN.
- Accepted bit (`valid`=1 and `cfg_load`=0):
  - `hist_n = {hist[MAX_LEN-2:0], seq}`.
  - `fill_n = min(fill+1, MAX_LEN)`.
- Match condition: `len_e` ≠ 0, `fill_n` ≥ `len_e`, and `(hist_n & mask) == (pat_q & mask)`, where `mask = (1<<len_e)-1`.
- On a match:
  - `detected` is 1 next cycle.
  - `match_count` increments, saturating.
  - If `ovl_q` = 0, `fill` is forced to 0 instead of `fill_n`. `hist` still shifts but is ignored until refilled.
- `valid` = 0: `hist`, `fill` and `match_count` are held; `detected` is 0 next cycle.
- `cfg_load` = 1:
  - Latches `pat_q`, `len_q` (clamped) and `ovl_q`.
  - Clears `hist`, `fill` and `match_count` to 0.
  - `detected` is 0 next cycle.
  - Any simultaneous `valid` bit is discarded; `cfg_load` wins.
- Changing `cfg_*` without `cfg_load` has no effect.

## Timing
- Reset, `detected`: 0.
- Reset, `match_count`: 0.
- Reset, `hist`/`fill`: 0.
- Reset, configuration: the defaults above.
- `reset` has priority over `cfg_load` and `valid`. Reset mid-stream discards partial matches.
- Latency: an accepted bit at edge N gives `detected` high from edge N until edge N+1, i.e. a registered output.
- Back-to-back matches:
  - In overlap mode, two matches can be as close as consecutive accepted bits, e.g. pattern `11`, len 2.
  - In non-overlap mode, consecutive matches are at least `len_e` accepted bits apart.
- `match_count` updates on the same edge that raises `detected`. At all-ones, a match still pulses `detected` but the count holds.
- Gaps in `valid` are transparent: matches span idle cycles.

## Configuration
- Macro `SEQDET_MATCH_COUNTER_EN`.
- Defined: the CNT_W saturating counter is built as described.
- Undefined: no counter register; the `match_count` port remains and is tied to 0. `detected` behaviour is identical.

## Test plan
- Reset defaults: pattern `10110`, len 5, overlap on.
  - Stimulus: stream `1,0,1,1,0,1,1,0` with `valid` always high.
  - Response: `detected` pulses after bits 5 and 8; `match_count` = 2.
- Non-overlap: `cfg_load` with pattern `10110`, len 5, `cfg_overlap`=0, then the same stream.
  - Response: single pulse after bit 5; `match_count` = 1.
- Back-pressure gaps: default config, bits `1,0,1,1,0` with 3 idle `valid`=0 cycles between every bit.
  - Response: exactly one pulse, the cycle after the 5th accepted bit; no pulses during idle cycles.
- Length and clamp:
  - `cfg_len`=1, pattern `1`, stream `1,1,0,1` → 3 pulses.
  - `cfg_len`=MAX_LEN+1 loads `len_q`=MAX_LEN; the all-ones pattern detects only after MAX_LEN consecutive `1`s.
  - `cfg_len`=0 → no pulses on any stream.
- Load priority and mid-stream reset:
  - `cfg_load` together with the 5th bit of `10110` → no pulse; `match_count` = 0.
  - `reset` after 4 bits of `10110`, then bit `0` → no pulse.
- Saturation (with the macro, `CNT_W`=2): pattern `1`, len 1, 5 ones → 5 pulses; `match_count` sticks at 3.
